// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage, writer side of the IF/ID register.
//
// Owns the PC, runs the instruction-memory request/response handshake and
// presents {pc, pc+2, instr, halt} with a write enable to the IF/ID d-side.
// Handles hazard stalls (response parked in a hold buffer), redirects from
// later stages (a NOP bubble is written, and a stale response is dropped),
// and HALT (fetch stops until a redirect or reset).
//
// Ports:
//   clk, rst (async, active-low)
//   stall, redirect, redirect_pc            control from hazard/branch logic
//   imem_req, imem_addr, imem_rdata,
//   imem_valid                              instruction-memory handshake
//   ifid_wen, ifid_pc_out, ifid_pc_inc,
//   ifid_instr, ifid_halt                   IF/ID write port
//   halted                                  fetch stopped on HALT
//
// Optional feature, macro FETCH_PERF_EN: adds saturating counters
//   perf_fetched (real instructions written) and perf_stall (stall cycles
//   seen in FETCH or HOLD).
module fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE = 4'hF,
   parameter logic [15:0] NOP_INSTR   = 16'hA000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_valid,
   output logic        ifid_wen,
   output logic [15:0] ifid_pc_out,
   output logic [15:0] ifid_pc_inc,
   output logic [15:0] ifid_instr,
   output logic        ifid_halt,
`ifdef FETCH_PERF_EN
   output logic [15:0] perf_fetched,
   output logic [15:0] perf_stall,
`endif
   output logic        halted
);

   typedef enum logic [1:0] {FETCH, HOLD, DISCARD, HALTED} state_t;

   state_t      state, state_nx;
   logic [15:0] pc, pc_nx;
   logic [15:0] hold_instr, hold_instr_nx;
   logic [15:0] hold_pc, hold_pc_nx;

   always_comb begin
      state_nx      = state;
      pc_nx         = pc;
      hold_instr_nx = hold_instr;
      hold_pc_nx    = hold_pc;
      imem_req      = (state == FETCH);
      imem_addr     = pc;
      ifid_wen      = 1'b0;
      ifid_pc_out   = 16'h0000;
      ifid_pc_inc   = 16'h0000;
      ifid_instr    = 16'h0000;
      ifid_halt     = 1'b0;
      halted        = (state == HALTED);

      if (redirect) begin
         pc_nx       = redirect_pc;
         ifid_wen    = 1'b1;
         ifid_pc_out = redirect_pc;
         ifid_pc_inc = redirect_pc;
         ifid_instr  = NOP_INSTR;
         // A request still in flight must have its response swallowed.
         if ((state == FETCH || state == DISCARD) && !imem_valid)
            state_nx = DISCARD;
         else
            state_nx = FETCH;
      end else begin
         case (state)
            FETCH: begin
               ifid_pc_out = pc;
               ifid_pc_inc = pc + 16'd2;
               ifid_instr  = imem_rdata;
               if (imem_valid) begin
                  if (!stall) begin
                     ifid_wen  = 1'b1;
                     ifid_halt = (imem_rdata[15:12] == HALT_OPCODE);
                     if (ifid_halt) state_nx = HALTED;
                     else           pc_nx    = pc + 16'd2;
                  end else begin
                     // Memory pulses valid once; park the word until IF/ID frees up.
                     hold_instr_nx = imem_rdata;
                     hold_pc_nx    = pc;
                     state_nx      = HOLD;
                  end
               end
            end
            HOLD: begin
               ifid_pc_out = hold_pc;
               ifid_pc_inc = hold_pc + 16'd2;
               ifid_instr  = hold_instr;
               if (!stall) begin
                  ifid_wen  = 1'b1;
                  ifid_halt = (hold_instr[15:12] == HALT_OPCODE);
                  if (ifid_halt) begin
                     state_nx = HALTED;
                  end else begin
                     pc_nx    = hold_pc + 16'd2;
                     state_nx = FETCH;
                  end
               end
            end
            DISCARD: begin
               if (imem_valid) state_nx = FETCH;
            end
            default: ; // HALTED: wait for redirect or reset
         endcase
      end

      if (!rst) begin
         imem_req    = 1'b0;
         imem_addr   = 16'h0000;
         ifid_wen    = 1'b0;
         ifid_pc_out = 16'h0000;
         ifid_pc_inc = 16'h0000;
         ifid_instr  = 16'h0000;
         ifid_halt   = 1'b0;
         halted      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         hold_instr <= 16'h0000;
         hold_pc    <= 16'h0000;
      end else begin
         state      <= state_nx;
         pc         <= pc_nx;
         hold_instr <= hold_instr_nx;
         hold_pc    <= hold_pc_nx;
      end
   end

`ifdef FETCH_PERF_EN
   logic fetched_inc, stall_inc;
   assign fetched_inc = ifid_wen && !redirect && (ifid_instr != NOP_INSTR);
   assign stall_inc   = stall && (state == FETCH || state == HOLD);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= 16'h0000;
         perf_stall   <= 16'h0000;
      end else begin
         if (fetched_inc && perf_fetched != 16'hFFFF) perf_fetched <= perf_fetched + 16'd1;
         if (stall_inc   && perf_stall   != 16'hFFFF) perf_stall   <= perf_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- scoreboard bench for fetch_unit. Every IF/ID write the
// stimulus should cause is queued when driven; a negedge monitor pops and
// compares each write the DUT actually makes.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall, redirect, imem_valid;
   logic [15:0] redirect_pc, imem_rdata;
   logic        imem_req, ifid_wen, ifid_halt, halted;
   logic [15:0] imem_addr, ifid_pc_out, ifid_pc_inc, ifid_instr;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched, perf_stall;
`endif

   fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid), .ifid_wen(ifid_wen),
      .ifid_pc_out(ifid_pc_out), .ifid_pc_inc(ifid_pc_inc),
      .ifid_instr(ifid_instr), .ifid_halt(ifid_halt),
`ifdef FETCH_PERF_EN
      .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
      .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] inc;
      logic [15:0] instr;
      logic        halt;
   } wr_t;

   wr_t q[$];
   int  n_chk  = 0;
   int  n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   task automatic exp_wr(input logic [15:0] pc, input logic [15:0] inc,
                         input logic [15:0] instr, input logic halt);
      wr_t e;
      e.pc = pc; e.inc = inc; e.instr = instr; e.halt = halt;
      q.push_back(e);
   endtask

   // One clock: drive inputs just after posedge, return at negedge.
   task automatic cyc(input logic v, input logic [15:0] d, input logic st,
                      input logic rd, input logic [15:0] rpc);
      @(posedge clk);
      #1;
      imem_valid = v; imem_rdata = d; stall = st; redirect = rd; redirect_pc = rpc;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst && ifid_wen) begin
         if (q.size() == 0) begin
            chk("sb_unexpected_wr", 32'd1, 32'd0);
         end else begin
            wr_t e;
            e = q.pop_front();
            chk("wr_pc_out", {16'h0, ifid_pc_out}, {16'h0, e.pc});
            chk("wr_pc_inc", {16'h0, ifid_pc_inc}, {16'h0, e.inc});
            chk("wr_instr",  {16'h0, ifid_instr},  {16'h0, e.instr});
            chk("wr_halt",   {31'h0, ifid_halt},   {31'h0, e.halt});
         end
      end
   end

   initial begin
      rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
      imem_valid = 1'b0; imem_rdata = 16'h0;
      #3;
      chk("rst_req",  {31'h0, imem_req}, 32'd0);
      chk("rst_wen",  {31'h0, ifid_wen}, 32'd0);
      chk("rst_halted", {31'h0, halted}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;

      // zero-latency back-to-back fetch
      exp_wr(16'h0000, 16'h0002, 16'h1234, 1'b0);
      cyc(1, 16'h1234, 0, 0, 0);
      chk("s1_addr0", {16'h0, imem_addr}, 32'h0000);
      chk("s1_req",   {31'h0, imem_req},  32'd1);
      exp_wr(16'h0002, 16'h0004, 16'h2345, 1'b0);
      cyc(1, 16'h2345, 0, 0, 0);
      chk("s1_addr1", {16'h0, imem_addr}, 32'h0002);

      // response arrives under stall -> HOLD for 3 stalled cycles
      cyc(1, 16'h5678, 1, 0, 0);
      chk("s2_wen_cap", {31'h0, ifid_wen}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 16'h0, 1, 0, 0);
         chk("s2_hold_wen", {31'h0, ifid_wen}, 32'd0);
         chk("s2_hold_req", {31'h0, imem_req}, 32'd0);
      end
      exp_wr(16'h0004, 16'h0006, 16'h5678, 1'b0);
      cyc(0, 16'h0, 0, 0, 0);
      chk("s2_rel_wen", {31'h0, ifid_wen}, 32'd1);

      // redirect with request outstanding; stale response 2 cycles later
      cyc(0, 16'h0, 0, 0, 0);
      chk("s3_addr6", {16'h0, imem_addr}, 32'h0006);
      exp_wr(16'h0040, 16'h0040, 16'hA000, 1'b0);
      cyc(0, 16'h0, 0, 1, 16'h0040);
      cyc(0, 16'h0, 0, 0, 0);
      chk("s3_disc_req", {31'h0, imem_req}, 32'd0);
      cyc(1, 16'hBEEF, 0, 0, 0);
      chk("s3_stale_wen", {31'h0, ifid_wen}, 32'd0);
      exp_wr(16'h0040, 16'h0042, 16'h1111, 1'b0);
      cyc(1, 16'h1111, 0, 0, 0);
      chk("s3_addr40", {16'h0, imem_addr}, 32'h0040);

      // redirect with same-cycle valid, then HALT at 0x0010
      exp_wr(16'h0010, 16'h0010, 16'hA000, 1'b0);
      cyc(1, 16'h9999, 0, 1, 16'h0010);
      exp_wr(16'h0010, 16'h0012, 16'hF000, 1'b1);
      cyc(1, 16'hF000, 0, 0, 0);
      chk("s4_halt_now", {31'h0, halted}, 32'd0);
      cyc(0, 16'h0, 0, 0, 0);
      chk("s4_halted", {31'h0, halted},   32'd1);
      chk("s4_req",    {31'h0, imem_req}, 32'd0);
      cyc(1, 16'h7777, 0, 0, 0);
      chk("s4_halt_wen", {31'h0, ifid_wen}, 32'd0);
      exp_wr(16'h0020, 16'h0020, 16'hA000, 1'b0);
      cyc(0, 16'h0, 0, 1, 16'h0020);
      exp_wr(16'h0020, 16'h0022, 16'h3333, 1'b0);
      cyc(1, 16'h3333, 0, 0, 0);
      chk("s4_resume", {16'h0, imem_addr}, 32'h0020);
      chk("s4_unhalt", {31'h0, halted},    32'd0);

      // pc wrap; redirect written despite stall
      exp_wr(16'hFFFE, 16'hFFFE, 16'hA000, 1'b0);
      cyc(1, 16'h0, 1, 1, 16'hFFFE);
      exp_wr(16'hFFFE, 16'h0000, 16'h4444, 1'b0);
      cyc(1, 16'h4444, 0, 0, 0);
      cyc(0, 16'h0, 0, 0, 0);
      chk("s5_wrap", {16'h0, imem_addr}, 32'h0000);
      exp_wr(16'h0000, 16'h0002, 16'h5555, 1'b0);
      cyc(1, 16'h5555, 0, 0, 0);

      // async reset mid-request
      cyc(0, 16'h0, 0, 0, 0);
      chk("s6_pre_addr", {16'h0, imem_addr}, 32'h0002);
      #2 rst = 1'b0;
      #1;
      chk("s6_req",  {31'h0, imem_req},   32'd0);
      chk("s6_addr", {16'h0, imem_addr},  32'd0);
      chk("s6_wen",  {31'h0, ifid_wen},   32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("s6_rel_addr", {16'h0, imem_addr}, 32'h0000);
      chk("s6_rel_req",  {31'h0, imem_req},  32'd1);

      chk("sb_empty", q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
